keypoint_reader: RTL and testbench
==================================

Name: keypoint_reader

Overview:
- Reads back the two keypoint SRAMs (layer 0 and layer 1) filled by the detect/filter stage. Streams every stored keypoint as {layer, row, col} over a valid/ready interface to the downstream descriptor/orientation stage.
- Sits between the keypoint SRAM read ports and the descriptor pipeline. Runs once per frame after detection reports done.
- Drains layer 0 completely, then layer 1, with full backpressure support and one keypoint per cycle sustained throughput.

Parameters:
- ROW_W, 9, row field width (480 rows)
- COL_W, 10, column field width (640 cols)
- ADDR_W, 11, keypoint SRAM address width (2048 entries per layer)
- FIFO_DEPTH, 2, output skid FIFO depth; fixed at 2 for this block

Ports:
- clk  in  1  clock
- rst_n  in  1  reset; synchronous, active-low
- start  in  1  one-cycle pulse, begin readout; ignored unless IDLE
- kp0_count  in  ADDR_W+1  number of valid entries in layer-0 SRAM (0..2048), sampled on start
- kp1_count  in  ADDR_W+1  same for layer-1 SRAM
- kp0_addr  out  ADDR_W  layer-0 SRAM read address (registered)
- kp0_dout  in  ROW_W+COL_W  layer-0 SRAM data {row[18:10], col[9:0]}
- kp1_addr  out  ADDR_W  layer-1 SRAM read address (registered)
- kp1_dout  in  ROW_W+COL_W  layer-1 SRAM data, same packing
- kp_valid  out  1  output keypoint valid
- kp_ready  in  1  downstream accept
- kp_layer  out  1  0 = layer-0 SRAM, 1 = layer-1 SRAM
- kp_row  out  ROW_W  keypoint row
- kp_col  out  COL_W  keypoint column
- busy  out  1  high from the cycle after start until done
- done  out  1  one-cycle pulse after the last keypoint is accepted

Behaviour:
- Reset outputs: kp0_addr=0, kp1_addr=0, kp_valid=0, kp_layer=0, kp_row=0, kp_col=0, busy=0, done=0. FIFO and in-flight tracker are emptied; state = IDLE.
- SRAM timing: dout in cycle n+1 reflects the address registered at the end of cycle n (1-cycle read latency).
- Counts latched on start. Values >2048 clamp to 2048.
- FSM states:
  - IDLE --start--> RD0.
  - RD0: issue reads at kp0_addr 0..cnt0-1. After the last issue -> RD1. If cnt0==0, go directly to RD1 with no issue.
  - RD1: same on kp1_addr. After the last issue, or if cnt1==0 -> DRAIN.
  - DRAIN: wait until the FIFO and in-flight tracker are empty -> DONE.
  - DONE: assert done for one cycle, drop busy -> IDLE.
- Issue rule: a read issues in a cycle iff (fifo_count + inflight − pop) < FIFO_DEPTH, where pop = kp_valid & kp_ready. A read returning in cycle n+1 is pushed into the FIFO with its layer tag.
- Address advance: the address register increments on each issue. It returns to 0 when its layer finishes and on entry to IDLE. At cnt=2048 the last address is 2047 and there is no wrap-around issue.
- Output: kp_valid = FIFO non-empty, fields come from the FIFO head. Fields are held stable while kp_valid & !kp_ready. Order is strictly layer 0 ascending address, then layer 1 ascending.
- Throughput: with kp_ready held high, one keypoint per cycle. First kp_valid is asserted 3 cycles after the start-sampling edge.
- Both counts zero: start -> done pulse with no kp_valid. busy is high for the intervening cycles.
- start while busy is ignored, and the counts are not relatched.
- Synchronous reset mid-readout: outputs take their reset values next cycle. In-flight SRAM data is discarded and no done pulse is generated.
- Row/col packing: row = dout[18:10], col = dout[9:0], passed through unmodified.

Decomposition:
- Shared package holds ROW_W, COL_W, ADDR_W, the keypoint word width (ROW_W+COL_W), and the FSM state encoding for IDLE/RD0/RD1/DRAIN/DONE.
- One sub-module is natural: kp_skid_fifo. It is a 2-entry synchronous FIFO of {layer, row, col} with push, pop, count, and registered head.

Test Plan:
- cnt0=3 (entries {5,10},{5,20},{7,639}), cnt1=2 ({1,1},{478,2}), kp_ready=1 -> 5 consecutive beats: L0 (5,10),(5,20),(7,639), then L1 (1,1),(478,2). First kp_valid is 3 cycles after start; done pulses 1 cycle after the 5th accept.
- Same data, kp_ready toggled 1,0,0,1,0,1... -> identical order, no drop or duplicate, fields stable during stalls, addresses never exceed count−1.
- cnt0=0, cnt1=0 -> no kp_valid, exactly one done pulse, kp0_addr/kp1_addr remain 0.
- cnt0=2048 with address-coded data, cnt1=1 -> 2049 beats. Last L0 beat comes from addr 2047, followed by the single L1 beat.
- start pulsed again mid-readout with different counts -> ignored, original sequence completes.
- rst_n low for 1 cycle during RD1 with kp_ready=0 -> all outputs at reset values next cycle, no done. A subsequent start re-reads from address 0.

Source files
------------

// File: rtl/keypoint_reader_pkg.sv
// Shared widths, keypoint record type and readout FSM encoding for keypoint_reader.
package keypoint_reader_pkg;

    localparam int ROW_W      = 9;
    localparam int COL_W      = 10;
    localparam int ADDR_W     = 11;
    localparam int KP_W       = ROW_W + COL_W;
    localparam int FIFO_DEPTH = 2;

    localparam logic [ADDR_W:0] KP_DEPTH = {1'b1, {ADDR_W{1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD0,
        S_RD1,
        S_DRAIN,
        S_DONE
    } state_e;

    typedef struct packed {
        logic             layer;
        logic [ROW_W-1:0] row;
        logic [COL_W-1:0] col;
    } kp_t;

    function automatic logic [ADDR_W:0] clamp_count(input logic [ADDR_W:0] c);
        return (c > KP_DEPTH) ? KP_DEPTH : c;
    endfunction

endpackage

// File: rtl/keypoint_reader_if.sv
// Keypoint stream valid/ready bus toward the descriptor/orientation stage.
interface keypoint_reader_if;
    import keypoint_reader_pkg::*;

    logic             kp_valid;
    logic             kp_ready;
    logic             kp_layer;
    logic [ROW_W-1:0] kp_row;
    logic [COL_W-1:0] kp_col;

    modport master (output kp_valid, kp_layer, kp_row, kp_col, input kp_ready);
    modport slave  (input kp_valid, kp_layer, kp_row, kp_col, output kp_ready);

endinterface

// File: rtl/keypoint_reader_kp_skid_fifo.sv
// Two-entry skid FIFO of {layer,row,col}; head is a register so it feeds the output bus directly.
module kp_skid_fifo
    import keypoint_reader_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic       push,
    input  kp_t        din,
    input  logic       pop,
    output logic [1:0] count,
    output kp_t        head
);

    kp_t tail_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            count  <= '0;
            head   <= '0;
            tail_q <= '0;
        end else begin
            case ({push, pop})
                2'b10: begin
                    if (count == 2'd0) head <= din;
                    else               tail_q <= din;
                    count <= count + 2'd1;
                end
                2'b01: begin
                    head  <= tail_q;
                    count <= count - 2'd1;
                end
                2'b11: begin
                    if (count == 2'd1) begin
                        head <= din;
                    end else begin
                        head   <= tail_q;
                        tail_q <= din;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/keypoint_reader.sv
// Drains layer-0 then layer-1 keypoint SRAMs into a valid/ready stream, one keypoint per cycle.
module keypoint_reader
    import keypoint_reader_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic [ADDR_W:0]   kp0_count,
    input  logic [ADDR_W:0]   kp1_count,
    output logic [ADDR_W-1:0] kp0_addr,
    input  logic [KP_W-1:0]   kp0_dout,
    output logic [ADDR_W-1:0] kp1_addr,
    input  logic [KP_W-1:0]   kp1_dout,
    keypoint_reader_if.master kp,
    output logic              busy,
    output logic              done
);

    state_e          state_q, state_d;
    logic [ADDR_W:0] cnt0_q, cnt1_q;
    logic            inflight_q, inflight_layer_q;
    logic            issue0, issue1, last0, last1, pop, room;
    logic [1:0]      fifo_count;
    kp_t             fifo_din, fifo_head;

    assign pop = kp.kp_valid & kp.kp_ready;
    // count + inflight - pop < FIFO_DEPTH, rearranged to avoid an underflowing subtract
    assign room  = ({1'b0, fifo_count} + {2'b0, inflight_q}) < (3'(FIFO_DEPTH) + {2'b0, pop});
    assign last0 = ({1'b0, kp0_addr} == cnt0_q - (ADDR_W+1)'(1));
    assign last1 = ({1'b0, kp1_addr} == cnt1_q - (ADDR_W+1)'(1));

    always_comb begin
        state_d = state_q;
        issue0  = 1'b0;
        issue1  = 1'b0;
        case (state_q)
            S_IDLE: if (start) state_d = S_RD0;
            S_RD0: begin
                if (cnt0_q == '0) begin
                    state_d = S_RD1;
                end else if (room) begin
                    issue0 = 1'b1;
                    if (last0) state_d = S_RD1;
                end
            end
            S_RD1: begin
                if (cnt1_q == '0) begin
                    state_d = S_DRAIN;
                end else if (room) begin
                    issue1 = 1'b1;
                    if (last1) state_d = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (({1'b0, fifo_count} + {2'b0, inflight_q}) == {2'b0, pop}) state_d = S_DONE;
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q          <= S_IDLE;
            cnt0_q           <= '0;
            cnt1_q           <= '0;
            kp0_addr         <= '0;
            kp1_addr         <= '0;
            inflight_q       <= 1'b0;
            inflight_layer_q <= 1'b0;
        end else begin
            state_q <= state_d;
            if (state_q == S_IDLE && start) begin
                cnt0_q <= clamp_count(kp0_count);
                cnt1_q <= clamp_count(kp1_count);
            end
            if (issue0) kp0_addr <= last0 ? '0 : kp0_addr + ADDR_W'(1);
            if (issue1) kp1_addr <= last1 ? '0 : kp1_addr + ADDR_W'(1);
            if (state_q == S_DONE) begin
                kp0_addr <= '0;
                kp1_addr <= '0;
            end
            inflight_q       <= issue0 | issue1;
            inflight_layer_q <= issue1;
        end
    end

    assign fifo_din = inflight_layer_q ? kp_t'({1'b1, kp1_dout}) : kp_t'({1'b0, kp0_dout});

    kp_skid_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (inflight_q),
        .din   (fifo_din),
        .pop   (pop),
        .count (fifo_count),
        .head  (fifo_head)
    );

    assign kp.kp_valid = (fifo_count != 2'd0);
    assign kp.kp_layer = fifo_head.layer;
    assign kp.kp_row   = fifo_head.row;
    assign kp.kp_col   = fifo_head.col;

    assign busy = (state_q == S_RD0) || (state_q == S_RD1) || (state_q == S_DRAIN);
    assign done = (state_q == S_DONE);

endmodule

// File: tb/tb_keypoint_reader.sv
// Directed bench for keypoint_reader: SRAM models, hand-computed keypoint order and handshake timing.
module tb_keypoint_reader;
    import keypoint_reader_pkg::*;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              start = 1'b0;
    logic [ADDR_W:0]   kp0_count = '0;
    logic [ADDR_W:0]   kp1_count = '0;
    logic [ADDR_W-1:0] kp0_addr, kp1_addr;
    logic [KP_W-1:0]   kp0_dout, kp1_dout;
    logic              busy, done;

    logic [KP_W-1:0]   mem0 [0:(1<<ADDR_W)-1];
    logic [KP_W-1:0]   mem1 [0:(1<<ADDR_W)-1];
    logic [KP_W:0]     exp_q [$];
    logic [5:0]        rdy_pat = 6'b101001;
    int                n_checks = 0;
    int                n_fail = 0;

    keypoint_reader_if kp_if ();

    keypoint_reader dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .start     (start),
        .kp0_count (kp0_count),
        .kp1_count (kp1_count),
        .kp0_addr  (kp0_addr),
        .kp0_dout  (kp0_dout),
        .kp1_addr  (kp1_addr),
        .kp1_dout  (kp1_dout),
        .kp        (kp_if),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    always_ff @(posedge clk) begin
        kp0_dout <= mem0[kp0_addr];
        kp1_dout <= mem1[kp1_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_kp0_addr"}, 32'(kp0_addr), 32'd0);
        check({tag, "_kp1_addr"}, 32'(kp1_addr), 32'd0);
        check({tag, "_kp_valid"}, 32'(kp_if.kp_valid), 32'd0);
        check({tag, "_kp_layer"}, 32'(kp_if.kp_layer), 32'd0);
        check({tag, "_kp_row"},   32'(kp_if.kp_row), 32'd0);
        check({tag, "_kp_col"},   32'(kp_if.kp_col), 32'd0);
        check({tag, "_busy"},     32'(busy), 32'd0);
        check({tag, "_done"},     32'(done), 32'd0);
    endtask

    task automatic push_small();
        exp_q.delete();
        exp_q.push_back({1'b0, 9'd5,   10'd10});
        exp_q.push_back({1'b0, 9'd5,   10'd20});
        exp_q.push_back({1'b0, 9'd7,   10'd639});
        exp_q.push_back({1'b1, 9'd1,   10'd1});
        exp_q.push_back({1'b1, 9'd478, 10'd2});
    endtask

    task automatic load_expect(input int c0, input int c1);
        exp_q.delete();
        for (int i = 0; i < c0; i++) exp_q.push_back({1'b0, mem0[i]});
        for (int i = 0; i < c1; i++) exp_q.push_back({1'b1, mem1[i]});
    endtask

    task automatic pulse_start(input int c0, input int c1);
        @(negedge clk);
        start     = 1'b1;
        kp0_count = (ADDR_W+1)'(c0);
        kp1_count = (ADDR_W+1)'(c1);
        @(negedge clk);
        start     = 1'b0;
    endtask

    // Entered at the first negedge after the start-sampling edge (cycle 1).
    task automatic run_stream(input int lim0, input int lim1, input int mode,
                              input int restart_at, input int max_cyc);
        int        cyc = 1;
        int        first_valid = -1;
        int        last_acc = -1;
        int        beats = 0;
        int        n_exp;
        bit        fin = 1'b0;
        bit        stalled = 1'b0;
        logic [KP_W:0] held = '0;
        logic [KP_W:0] cur;
        n_exp = exp_q.size();
        while (!fin && cyc <= max_cyc) begin
            kp_if.kp_ready = (mode == 0) ? 1'b1 : rdy_pat[cyc % 6];
            start = (cyc == restart_at);
            if (cyc == restart_at) begin
                kp0_count = (ADDR_W+1)'(1);
                kp1_count = (ADDR_W+1)'(1);
            end
            cur = {kp_if.kp_layer, kp_if.kp_row, kp_if.kp_col};
            if (done) begin
                fin = 1'b1;
                check("done_busy_low", 32'(busy), 32'd0);
                check("done_no_valid", 32'(kp_if.kp_valid), 32'd0);
                if (n_exp > 0) check("done_latency", 32'(cyc - last_acc), 32'd1);
            end else begin
                check("busy_high", 32'(busy), 32'd1);
                check("addr0_bound", 32'(int'(kp0_addr) <= lim0), 32'd1);
                check("addr1_bound", 32'(int'(kp1_addr) <= lim1), 32'd1);
                if (stalled) begin
                    check("hold_valid", 32'(kp_if.kp_valid), 32'd1);
                    check("hold_fields", 32'(cur), 32'(held));
                end
                stalled = 1'b0;
                if (kp_if.kp_valid) begin
                    if (first_valid < 0) first_valid = cyc;
                    if (kp_if.kp_ready) begin
                        if (exp_q.size() == 0) check("extra_beat", 32'(beats + 1), 32'(n_exp));
                        else                   check("beat", 32'(cur), 32'(exp_q.pop_front()));
                        beats++;
                        last_acc = cyc;
                    end else begin
                        held    = cur;
                        stalled = 1'b1;
                    end
                end
                @(negedge clk);
                cyc++;
            end
        end
        start = 1'b0;
        check("done_seen", 32'(fin), 32'd1);
        check("beat_count", 32'(beats), 32'(n_exp));
        if (n_exp > 0) check("first_valid_cycle", 32'(first_valid), 32'd3);
        @(negedge clk);
        check("done_one_pulse", 32'(done), 32'd0);
        check("idle_not_busy", 32'(busy), 32'd0);
        kp_if.kp_ready = 1'b0;
    endtask

    initial begin
        kp_if.kp_ready = 1'b0;
        for (int i = 0; i < (1 << ADDR_W); i++) begin
            mem0[i] = '0;
            mem1[i] = '0;
        end
        mem0[0] = {9'd5, 10'd10};
        mem0[1] = {9'd5, 10'd20};
        mem0[2] = {9'd7, 10'd639};
        mem1[0] = {9'd1, 10'd1};
        mem1[1] = {9'd478, 10'd2};

        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        repeat (2) @(negedge clk);

        // Full-rate readout
        push_small();
        pulse_start(3, 2);
        run_stream(2, 1, 0, -1, 60);

        // Backpressure with ready pattern 1,0,0,1,0,1
        push_small();
        pulse_start(3, 2);
        run_stream(2, 1, 1, -1, 80);

        // Both layers empty
        exp_q.delete();
        pulse_start(0, 0);
        run_stream(0, 0, 0, -1, 40);

        // Restart attempt while busy must not relatch counts
        push_small();
        pulse_start(3, 2);
        run_stream(2, 1, 0, 2, 60);

        // Reset while stalled in the layer-1 phase
        pulse_start(2, 2);
        repeat (5) @(negedge clk);
        check("stall_valid", 32'(kp_if.kp_valid), 32'd1);
        check("stall_busy", 32'(busy), 32'd1);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        check_reset_outputs("midrst");
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            check("no_done_after_rst", 32'(done), 32'd0);
            check("idle_after_rst", 32'(busy), 32'd0);
        end
        push_small();
        pulse_start(3, 2);
        run_stream(2, 1, 0, -1, 60);

        // Full layer-0 depth with address-coded data
        for (int i = 0; i < (1 << ADDR_W); i++) mem0[i] = KP_W'(i * 193 + 7);
        mem1[0] = {9'd300, 10'd700};
        load_expect(2048, 1);
        check("last_l0_from_2047", 32'(exp_q[2047]), 32'({1'b0, KP_W'(2047 * 193 + 7)}));
        pulse_start(2048, 1);
        run_stream(2047, 0, 0, -1, 2200);

        // Oversized count clamps to full depth
        load_expect(2048, 0);
        pulse_start(4095, 0);
        run_stream(2047, 0, 1, -1, 6000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
